// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - picks a random mole, lights it until hit/miss/watchdog, repeats for a round.
// Optional MOLE_NO_REPEAT_EN: never light the same mole twice in a row within a round.
module mole_spawner #(
  parameter int N_MOLES       = 10,
  parameter int GAP_TICKS     = 250,
  parameter int TIMEOUT_TICKS = 2000,
  parameter int ROUND_MOLES   = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic [4:0]         rng_value,
  input  logic               hit_pulse,
  input  logic               miss_pulse,
  output logic [N_MOLES-1:0] active_onehot,
  output logic [4:0]         mole_idx,
  output logic               spawn_pulse,
  output logic               timeout_pulse,
  output logic [7:0]         moles_left,
  output logic               busy,
  output logic               round_done
);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_SPAWN, S_UP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        tick_cnt_q, tick_cnt_d;
  logic [7:0]         moles_left_q, moles_left_d;
  logic [4:0]         mole_idx_q, mole_idx_d;
  logic [N_MOLES-1:0] active_q, active_d;
  logic               spawn_q, spawn_d;
  logic               timeout_q, timeout_d;
  logic [4:0]         idx_raw, idx_sel;
  logic               mole_event, watchdog;

`ifdef MOLE_NO_REPEAT_EN
  logic first_q, first_d;
`endif

  always_comb begin
    idx_raw = 5'({27'd0, rng_value} % N_MOLES);
    idx_sel = idx_raw;
`ifdef MOLE_NO_REPEAT_EN
    // Bump a repeated pick to its neighbour; the round's first mole has no predecessor.
    if (!first_q && (idx_raw == mole_idx_q)) begin
      idx_sel = (idx_raw == 5'(N_MOLES - 1)) ? 5'd0 : idx_raw + 5'd1;
    end
`endif
  end

  assign mole_event = hit_pulse | miss_pulse;
  assign watchdog   = tick && (tick_cnt_q == 16'(TIMEOUT_TICKS - 1));

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    moles_left_d = moles_left_q;
    mole_idx_d   = mole_idx_q;
    active_d     = active_q;
    spawn_d      = 1'b0;
    timeout_d    = 1'b0;
`ifdef MOLE_NO_REPEAT_EN
    first_d      = first_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        active_d = '0;
        if (start) begin
          moles_left_d = 8'(ROUND_MOLES);
          tick_cnt_d   = 16'd0;
          state_d      = S_GAP;
`ifdef MOLE_NO_REPEAT_EN
          first_d      = 1'b1;
`endif
        end
      end
      S_GAP: begin
        if (tick) begin
          if (tick_cnt_q == 16'(GAP_TICKS - 1)) state_d = S_SPAWN;
          else tick_cnt_d = tick_cnt_q + 16'd1;
        end
      end
      S_SPAWN: begin
        mole_idx_d = idx_sel;
        active_d   = {{(N_MOLES-1){1'b0}}, 1'b1} << idx_sel;
        spawn_d    = 1'b1;
        tick_cnt_d = 16'd0;
        state_d    = S_UP;
`ifdef MOLE_NO_REPEAT_EN
        first_d    = 1'b0;
`endif
      end
      S_UP: begin
        if (mole_event || watchdog) begin
          // A hit/miss on the watchdog tick is a normal clear, not a timeout.
          timeout_d    = !mole_event;
          active_d     = '0;
          moles_left_d = moles_left_q - 8'd1;
          tick_cnt_d   = 16'd0;
          state_d      = (moles_left_q == 8'd1) ? S_DONE : S_GAP;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= 16'd0;
      moles_left_q <= 8'd0;
      mole_idx_q   <= 5'd0;
      active_q     <= '0;
      spawn_q      <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef MOLE_NO_REPEAT_EN
      first_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      moles_left_q <= moles_left_d;
      mole_idx_q   <= mole_idx_d;
      active_q     <= active_d;
      spawn_q      <= spawn_d;
      timeout_q    <= timeout_d;
`ifdef MOLE_NO_REPEAT_EN
      first_q      <= first_d;
`endif
    end
  end

  assign active_onehot = active_q;
  assign mole_idx      = mole_idx_q;
  assign spawn_pulse   = spawn_q;
  assign timeout_pulse = timeout_q;
  assign moles_left    = moles_left_q;
  assign busy          = (state_q == S_GAP) || (state_q == S_SPAWN) || (state_q == S_UP);
  assign round_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_mole_spawner.sv
// tb/tb_mole_spawner.sv - directed vector table plus randomized run against a reference model.
module tb_mole_spawner;
  localparam int N  = 10;
  localparam int GT = 3;
  localparam int TT = 4;
  localparam int RM = 3;

  logic         clk = 1'b0;
  logic         rst, tick, start, hit_pulse, miss_pulse;
  logic [4:0]   rng_value;
  logic [N-1:0] active_onehot;
  logic [4:0]   mole_idx;
  logic         spawn_pulse, timeout_pulse, busy, round_done;
  logic [7:0]   moles_left;

  mole_spawner #(.N_MOLES(N), .GAP_TICKS(GT), .TIMEOUT_TICKS(TT), .ROUND_MOLES(RM)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .rng_value(rng_value),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .active_onehot(active_onehot),
    .mole_idx(mole_idx), .spawn_pulse(spawn_pulse), .timeout_pulse(timeout_pulse),
    .moles_left(moles_left), .busy(busy), .round_done(round_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, start, tick, hit, miss;
    logic [4:0] rng;
    logic [N-1:0] act;
    logic [4:0] idx;
    logic sp, to;
    logic [7:0] left;
    logic bsy, dn;
  } vec_t;

  vec_t tbl[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: round progress as plain counters.
  // phase: 0 idle, 1 waiting gap, 2 picking, 3 mole up, 4 round over
  int m_phase, m_gap_seen, m_up_seen, m_left, m_idx, m_first;
  bit m_lit, m_sp, m_to;

  task automatic model_step();
    int pick;
    m_sp = 0;
    m_to = 0;
    if (rst) begin
      m_phase = 0; m_gap_seen = 0; m_up_seen = 0; m_left = 0; m_idx = 0; m_lit = 0; m_first = 0;
      return;
    end
    if (m_phase == 0 || m_phase == 4) begin
      if (start) begin m_phase = 1; m_left = RM; m_gap_seen = 0; m_first = 1; end
    end else if (m_phase == 1) begin
      if (tick) begin
        m_gap_seen++;
        if (m_gap_seen == GT) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      pick = int'(rng_value) % N;
`ifdef MOLE_NO_REPEAT_EN
      if (!m_first && pick == m_idx) pick = (pick + 1) % N;
`endif
      m_idx = pick; m_lit = 1; m_sp = 1; m_up_seen = 0; m_first = 0; m_phase = 3;
    end else begin
      if (tick) m_up_seen++;
      if (hit_pulse || miss_pulse || m_up_seen == TT) begin
        m_to = !(hit_pulse || miss_pulse);
        m_lit = 0;
        m_left--;
        m_gap_seen = 0;
        m_phase = (m_left == 0) ? 4 : 1;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [N-1:0] ea, logic [4:0] ei, logic es, logic et,
                       logic [7:0] el, logic eb, logic ed);
    n_checks++;
    if (active_onehot === ea && mole_idx === ei && spawn_pulse === es && timeout_pulse === et &&
        moles_left === el && busy === eb && round_done === ed) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got act=%h idx=%0d sp=%b to=%b left=%0d busy=%b done=%b want act=%h idx=%0d sp=%b to=%b left=%0d busy=%b done=%b",
               name, active_onehot, mole_idx, spawn_pulse, timeout_pulse, moles_left, busy, round_done,
               ea, ei, es, et, el, eb, ed);
    end
  endtask

  task automatic add(logic r, logic s, logic t, logic h, logic m, logic [4:0] g,
                     logic [N-1:0] a, logic [4:0] i, logic sp, logic to, logic [7:0] l,
                     logic b, logic d);
    vec_t v;
    v.rst = r; v.start = s; v.tick = t; v.hit = h; v.miss = m; v.rng = g;
    v.act = a; v.idx = i; v.sp = sp; v.to = to; v.left = l; v.bsy = b; v.dn = d;
    tbl.push_back(v);
  endtask

  initial begin
    logic [N-1:0] r2a;
    logic [4:0]   r2i;
    logic [N-1:0] ea;
`ifdef MOLE_NO_REPEAT_EN
    r2a = 10'h010; r2i = 5'd4;
`else
    r2a = 10'h008; r2i = 5'd3;
`endif
    //    rst st tk ht ms rng   act     idx sp to left b d
    add(1, 0, 0, 0, 0, 0,  10'h000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  10'h000, 0, 0, 0, 3, 1, 0);
    add(0, 0, 1, 0, 0, 0,  10'h000, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 0, 0,  10'h000, 0, 0, 0, 3, 1, 0);
    add(0, 0, 1, 0, 0, 0,  10'h000, 0, 0, 0, 3, 1, 0);
    add(0, 0, 1, 0, 0, 13, 10'h000, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 1, 0, 13, 10'h008, 3, 1, 0, 3, 1, 0);
    add(0, 0, 0, 0, 0, 0,  10'h008, 3, 0, 0, 3, 1, 0);
    add(0, 0, 0, 1, 1, 0,  10'h000, 3, 0, 0, 2, 1, 0);
    add(0, 1, 1, 0, 0, 0,  10'h000, 3, 0, 0, 2, 1, 0);
    add(0, 0, 1, 0, 0, 0,  10'h000, 3, 0, 0, 2, 1, 0);
    add(0, 0, 1, 0, 0, 13, 10'h000, 3, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 0, 13, r2a,   r2i, 1, 0, 2, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 0, 0, r2a, r2i, 0, 0, 2, 1, 0);
    add(0, 0, 1, 0, 0, 0,  10'h000, r2i, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,  10'h000, r2i, 0, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0,  10'h000, r2i, 0, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0,  10'h000, r2i, 0, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 7,  10'h000, r2i, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 7,  10'h080, 7, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0,  10'h000, 7, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  10'h000, 7, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0,  10'h000, 7, 0, 0, 3, 1, 0);
    add(0, 0, 1, 0, 0, 0,  10'h000, 7, 0, 0, 3, 1, 0);
    add(0, 0, 1, 0, 0, 0,  10'h000, 7, 0, 0, 3, 1, 0);
    add(0, 0, 1, 0, 0, 5,  10'h000, 7, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 0, 5,  10'h020, 5, 1, 0, 3, 1, 0);
    add(1, 0, 0, 1, 0, 0,  10'h000, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  10'h000, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  10'h000, 0, 0, 0, 0, 0, 0);

    rst = 1; start = 0; tick = 0; hit_pulse = 0; miss_pulse = 0; rng_value = 0;
    m_phase = 0; m_gap_seen = 0; m_up_seen = 0; m_left = 0; m_idx = 0; m_lit = 0;
    m_first = 0; m_sp = 0; m_to = 0;
    cycle();

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; start = tbl[i].start; tick = tbl[i].tick;
      hit_pulse = tbl[i].hit; miss_pulse = tbl[i].miss; rng_value = tbl[i].rng;
      cycle();
      check($sformatf("vec%0d", i), tbl[i].act, tbl[i].idx, tbl[i].sp, tbl[i].to,
            tbl[i].left, tbl[i].bsy, tbl[i].dn);
    end

    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 799) == 0);
      start      = ($urandom_range(0, 29) == 0);
      tick       = ($urandom_range(0, 2) == 0);
      hit_pulse  = ($urandom_range(0, 19) == 0);
      miss_pulse = ($urandom_range(0, 19) == 0);
      rng_value  = 5'($urandom);
      cycle();
      ea = m_lit ? (N'(1) << m_idx) : '0;
      check($sformatf("rand%0d", c), ea, 5'(m_idx), m_sp, m_to, 8'(m_left),
            (m_phase >= 1 && m_phase <= 3), (m_phase == 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
